// File: rtl/mac_mem_ctrl.sv
// mac_mem_ctrl: sequencer that owns the 16x8 operand memory during a run.
// It reads N operand pairs A[i], B[i], accumulates the unsigned dot product
// and writes the result back into the same memory, low byte first.
// Every output is a register, so nothing combinational reaches the ports.

module mac_mem_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    input  logic [ADDR_W-1:0] res_addr,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ACC_W-1:0]  acc_out,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_r_addr,
    input  logic [DATA_W-1:0] mem_r_data,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [DATA_W-1:0] mem_w_data
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_B  = 3'd2,
        MAC   = 3'd3,
        WR_LO = 3'd4,
        WR_HI = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t              state;

    // Run parameters latched at start so the caller may change its inputs mid-run
    logic [ADDR_W-1:0]   len_q;
    logic [ADDR_W-1:0]   a_base_q;
    logic [ADDR_W-1:0]   b_base_q;
    logic [ADDR_W-1:0]   res_addr_q;

    logic [ADDR_W-1:0]   idx;
    logic [ACC_W-1:0]    acc;
    logic [DATA_W-1:0]   a_reg;

    logic [2*DATA_W-1:0] prod;
    logic [ACC_W:0]      mac_sum;
    logic                last_pair;
    logic [ADDR_W-1:0]   next_idx;

    // Product of the held A operand with B arriving on the read port, summed one bit wider to expose the carry
    always_comb begin
        prod      = {{DATA_W{1'b0}}, a_reg} * {{DATA_W{1'b0}}, mem_r_data};
        mac_sum   = {1'b0, acc} + {{(ACC_W + 1 - 2 * DATA_W){1'b0}}, prod};
        last_pair = (idx == (len_q - ADDR_W'(1)));
        next_idx  = idx + ADDR_W'(1);
    end

    // Single state machine; outputs are loaded on the transition into the state in which they must be visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len_q      <= '0;
            a_base_q   <= '0;
            b_base_q   <= '0;
            res_addr_q <= '0;
            idx        <= '0;
            acc        <= '0;
            a_reg      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            acc_out    <= '0;
            mem_r_en   <= 1'b0;
            mem_r_addr <= '0;
            mem_w_en   <= 1'b0;
            mem_w_addr <= '0;
            mem_w_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        len_q      <= len;
                        a_base_q   <= a_base;
                        b_base_q   <= b_base;
                        res_addr_q <= res_addr;
                        idx        <= '0;
                        acc        <= '0;
                        overflow   <= 1'b0;
                        busy       <= 1'b1;
                        if (len != '0) begin
                            state      <= RD_A;
                            mem_r_en   <= 1'b1;
                            mem_r_addr <= a_base;
                        end else begin
                            state      <= WR_LO;
                            mem_w_en   <= 1'b1;
                            mem_w_addr <= res_addr;
                            mem_w_data <= '0;
                        end
                    end
                end

                RD_A: begin
                    state      <= RD_B;
                    mem_r_addr <= b_base_q + idx;
                end

                RD_B: begin
                    a_reg    <= mem_r_data;
                    mem_r_en <= 1'b0;
                    state    <= MAC;
                end

                MAC: begin
                    acc <= mac_sum[ACC_W-1:0];
                    if (mac_sum[ACC_W]) begin
                        overflow <= 1'b1;
                    end
                    idx <= next_idx;
                    if (last_pair) begin
                        state      <= WR_LO;
                        mem_w_en   <= 1'b1;
                        mem_w_addr <= res_addr_q;
                        mem_w_data <= mac_sum[DATA_W-1:0];
                    end else begin
                        state      <= RD_A;
                        mem_r_en   <= 1'b1;
                        mem_r_addr <= a_base_q + next_idx;
                    end
                end

                WR_LO: begin
                    state      <= WR_HI;
                    mem_w_addr <= res_addr_q + ADDR_W'(1);
                    mem_w_data <= acc[2*DATA_W-1:DATA_W];
                end

                WR_HI: begin
                    state    <= DONE;
                    mem_w_en <= 1'b0;
                    acc_out  <= acc;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    mem_r_en <= 1'b0;
                    mem_w_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mac_mem_ctrl.md
Name: mac_mem_ctrl

Overview:
Sequencer that drives the 16x8 operand memory's read and write ports. On a start pulse it reads N operand pairs (A[i], B[i]) and forms the 16-bit dot product sum(A[i]*B[i]). It writes the result back into the same memory as two bytes. It sits between the top-level control/test logic and the memory instance, and is the only master of the memory ports during a run.

Parameters:
DATA_W, 8, width of memory words and operands
ADDR_W, 4, memory address width (16 locations)
ACC_W, 16, accumulator and result width (written back as ACC_W/DATA_W = 2 bytes)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  run request, sampled only in IDLE
len  in  ADDR_W  number of operand pairs N, 0..15
a_base  in  ADDR_W  address of A[0]
b_base  in  ADDR_W  address of B[0]
res_addr  in  ADDR_W  address of result low byte; high byte goes to res_addr+1
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
overflow  out  1  sticky: sum exceeded ACC_W bits this run
acc_out  out  ACC_W  final accumulator value, held until next start
mem_r_en  out  1  memory read enable
mem_r_addr  out  ADDR_W  memory read address
mem_r_data  in  DATA_W  memory read data, registered in memory, valid the cycle after r_en
mem_w_en  out  1  memory write enable
mem_w_addr  out  ADDR_W  memory write address
mem_w_data  out  DATA_W  memory write data

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, overflow, mem_r_en, mem_w_en = 0; acc_out, addresses, mem_w_data, index, acc = 0. Takes effect immediately mid-run; no partial write completes after reset asserts.
- All outputs are driven from registered state (Moore). No combinational path from inputs to outputs.
- States: IDLE, RD_A, RD_B, MAC, WR_LO, WR_HI, DONE.
- IDLE: start=1 latches len, a_base, b_base, res_addr; clears acc, index i and overflow. If len!=0 -> RD_A, else -> WR_LO.
- RD_A: mem_r_en=1, mem_r_addr=a_base+i -> RD_B.
- RD_B: mem_r_en=1, mem_r_addr=b_base+i; capture mem_r_data (=A[i]) into a_reg -> MAC.
- MAC: mem_r_data = B[i]; acc <= acc + a_reg*mem_r_data (8x8 unsigned = 16-bit product, added at ACC_W+1 bits). A carry out sets overflow; acc keeps the low ACC_W bits. i<=i+1. If i==len-1 -> WR_LO, else -> RD_A.
- WR_LO: mem_w_en=1, mem_w_addr=res_addr, mem_w_data=acc[7:0] -> WR_HI.
- WR_HI: mem_w_en=1, mem_w_addr=res_addr+1, mem_w_data=acc[15:8]; acc_out<=acc -> DONE.
- DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
- busy=1 in every state except IDLE and DONE.
- Throughput: 3 cycles per pair. done is high in cycle 3N+3 after the edge that sampled start. For N=0, done is in cycle 3; 0x00,0x00 is written.
- All address arithmetic is modulo 2^ADDR_W (wrap 15->0), including res_addr+1.
- start while busy or in DONE is ignored and not queued.
- mem_r_en and mem_w_en are never high in the same cycle. All reads finish before the first write, so result addresses may overlap operand addresses.
- Unsigned arithmetic only.

Test Plan:
- mem[0]=3, mem[8]=5; len=1, a_base=0, b_base=8, res_addr=12 -> mem[12]=0x0F, mem[13]=0x00, acc_out=0x000F, overflow=0, done in cycle 6.
- mem[0..3]=1,2,3,4, mem[4..7]=5,6,7,8; len=4, res_addr=10 -> acc_out=70 (0x0046), mem[10]=0x46, mem[11]=0x00. mem_r_addr sequence is 0,4,1,5,2,6,3,7.
- All 16 words 0xFF; len=15, a_base=b_base=0 -> sum 975375, acc_out=0xE20F, overflow=1, mem[res_addr]=0x0F, mem[res_addr+1]=0xE2.
- Wrap: a_base=14, b_base=6, len=3, res_addr=15 -> reads addresses 14,15,0 for A and 6,7,8 for B; high byte written to address 0.
- start re-pulsed mid-run and len=0 run -> second start ignored, single done. len=0 gives writes of 0x00,0x00, done in cycle 3.
- rst_n low during RD_B of pair 2 -> all outputs 0 asynchronously, no memory writes, IDLE after release; a new start then runs normally.
